// File: rtl/imem_loader.sv
// Byte-stream boot loader: receives a length-prefixed little-endian image,
// writes it word by word into instruction memory and then releases the core.
module imem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      addr_q, addr_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign len_full  = {in_data, len_q[7:0]};
  assign last_word = (32'(word_idx_q) == (32'(len_q) - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  // Address is latched on the last byte so it stays stable for the whole WRITE cycle.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    data_d     = data_q;
    addr_d     = addr_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = LEN0;
      end
      LEN0: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          len_d = len_full;
          if ((len_full == 16'd0) || ({16'd0, len_full} > 32'(DEPTH_WORDS))) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            byte_idx_d = '0;
            word_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          data_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          byte_idx_d = '0;
          state_d    = DATA;
        end
      end
      DONE: begin
        if (start) state_d = LEN0;
      end
      ERR: begin
        if (start) state_d = LEN0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = data_q;
  assign core_hold  = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: images are generated here,
// streamed in, and the observed memory writes are compared to the image.
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int startEdge = 0;

  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  int          obsCyc[$];
  logic [31:0] img[DEPTH];

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Every write strobe seen by the memory is logged for later comparison.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obsAddr.push_back(imem_addr);
      obsData.push_back(imem_wdata);
      obsCyc.push_back(cycle);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    obsAddr.delete();
    obsData.delete();
    obsCyc.delete();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    startEdge = cycle;
  endtask

  // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random idle gaps
  task automatic sendByte(input logic [7:0] b, input int mode, input bit withStart);
    int  budget;
    bit  rdy;
    int  gap;
    gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    start    = withStart;
    budget   = 0;
    rdy      = 1'b0;
    while (!rdy && budget < 50) begin
      @(negedge clk);
      rdy = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      start = 1'b0;
      budget++;
    end
    checkOutput("byteAccepted", 32'(rdy), 32'd1);
  endtask

  task automatic fillImage(input int len);
    for (int i = 0; i < len && i < DEPTH; i++) img[i] = $urandom;
  endtask

  // Full load from DONE/ERR/IDLE; expectations come from the image and length rule.
  task automatic applyStimulus(input int len, input int mode, input int startByte);
    bit          expErr;
    int          k;
    int          byteNo;
    logic [15:0] lenBits;
    logic [31:0] w;
    expErr  = (len == 0) || (len > DEPTH);
    lenBits = 16'(len);
    clearLog();
    pulseStart();
    checkOutput("holdAfterStart", 32'(core_hold), 32'd1);
    checkOutput("doneAfterStart", 32'(done), 32'd0);
    checkOutput("errorAfterStart", 32'(error), 32'd0);
    sendByte(lenBits[7:0], mode, startByte == 0);
    sendByte(lenBits[15:8], mode, startByte == 1);
    byteNo = 2;
    if (!expErr) begin
      for (int wi = 0; wi < len; wi++) begin
        w = img[wi];
        for (int b = 0; b < 4; b++) begin
          sendByte(w[8*b +: 8], mode, startByte == byteNo);
          byteNo++;
        end
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (!(done === 1'b1 || error === 1'b1) && k < 40) begin
      tick();
      k++;
    end
    if (expErr) begin
      checkOutput("errFlag", 32'(error), 32'd1);
      checkOutput("errHold", 32'(core_hold), 32'd1);
      checkOutput("errDone", 32'(done), 32'd0);
      checkOutput("errWrites", 32'(obsAddr.size()), 32'd0);
    end else begin
      checkOutput("doneFlag", 32'(done), 32'd1);
      checkOutput("doneHold", 32'(core_hold), 32'd0);
      checkOutput("doneError", 32'(error), 32'd0);
      checkOutput("writeCount", 32'(obsAddr.size()), 32'(len));
      for (int i = 0; i < len && i < obsAddr.size(); i++) begin
        checkOutput($sformatf("addr[%0d]", i), obsAddr[i], 32'(4 * i));
        checkOutput($sformatf("data[%0d]", i), obsData[i], img[i]);
        if (mode == 0)
          checkOutput($sformatf("cycle[%0d]", i), 32'(obsCyc[i] - startEdge), 32'(6 + 5 * i));
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, ".imem_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, ".core_hold"}, 32'(core_hold), 32'd1);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".error"}, 32'(error), 32'd0);
    checkOutput({tag, ".addr"}, imem_addr, 32'd0);
    checkOutput({tag, ".wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    checkResetOutputs("reset");
    rst = 1'b0;
    tick();

    // Single-word image 13 05 A0 00, continuous stream
    img[0] = 32'h00A0_0513;
    applyStimulus(1, 0, -1);

    // Three words with in_valid toggling
    fillImage(3);
    applyStimulus(3, 1, -1);

    // Zero-length header, then a valid one-word load
    applyStimulus(0, 0, -1);
    fillImage(1);
    applyStimulus(1, 2, -1);

    // Over-capacity header, then a full-capacity image
    applyStimulus(257, 0, -1);
    fillImage(DEPTH);
    applyStimulus(DEPTH, 0, -1);
    checkOutput("lastAddr", (obsAddr.size() > 0) ? obsAddr[obsAddr.size() - 1] : 32'hFFFF_FFFF,
                32'h0000_03FC);

    // Reset in the middle of word 0
    fillImage(2);
    clearLog();
    pulseStart();
    sendByte(8'h02, 0, 1'b0);
    sendByte(8'h00, 0, 1'b0);
    sendByte(img[0][7:0], 0, 1'b0);
    sendByte(img[0][15:8], 0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("writesAfterReset", 32'(obsAddr.size()), 32'd0);
    checkOutput("idleHold", 32'(core_hold), 32'd1);
    applyStimulus(2, 0, -1);

    // start pulses during the header and data phases are ignored
    fillImage(2);
    applyStimulus(2, 0, 5);
    applyStimulus(2, 0, 1);

    // Random images and gap patterns
    for (int t = 0; t < 6; t++) begin
      int len;
      int mode;
      len  = int'($urandom_range(1, 8));
      mode = int'($urandom_range(0, 2));
      fillImage(len);
      applyStimulus(len, mode, int'($urandom_range(0, 4 * len + 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
